// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy encoding
// and the default bubble payload for instruction-carrying stages.
package pipe_stage_skid_pkg;

    // Bit 0 doubles as out_valid; 2'b10 is unreachable and recovers to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    function automatic logic state_has_main(input state_e st);
        return st[0];
    endfunction

    function automatic logic state_has_skid(input state_e st);
        return (st == ST_FULL);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Up-counter that sticks at all-ones; shared by the stall statistics and the
// hazard unit.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, synchronous flush
// that inserts bubbles, and a saturating back-pressure counter.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(MIPS_NOP),
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic main_valid;
    logic skid_valid;
    logic acc;
    logic take;

    assign main_valid = state_has_main(state_q);
    assign skid_valid = state_has_skid(state_q);

    // Ready only looks at registered occupancy and flush, never at out_ready.
    assign in_ready = ~skid_valid & ~flush;
    assign acc      = in_valid & in_ready;
    assign take     = main_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (acc && take) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (main_valid & ~out_ready),
        .q     (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks of pipe_stage_skid, plus a narrow-counter
// instance for saturation.
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] stall_cycles;

    logic        iv4;
    logic        or4;
    logic [7:0]  d4;
    logic        ir4;
    logic        ov4;
    logic [7:0]  od4;
    logic [3:0]  st4;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] RST_V = 32'hDEAD_BEEF;
    localparam logic [31:0] BUB_V = 32'h0000_0000;

    pipe_stage_skid #(
        .WIDTH      (32),
        .RESET_VAL  (RST_V),
        .BUBBLE_VAL (BUB_V),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .stall_cycles (stall_cycles)
    );

    pipe_stage_skid #(
        .WIDTH      (8),
        .RESET_VAL  (8'h00),
        .BUBBLE_VAL (8'h00),
        .CNT_W      (4)
    ) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (1'b0),
        .in_valid     (iv4),
        .in_ready     (ir4),
        .in_data      (d4),
        .out_valid    (ov4),
        .out_ready    (or4),
        .out_data     (od4),
        .stall_cycles (st4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic        exp_rdy;
        logic [15:0] stall_exp;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        iv4 = 1'b0; or4 = 1'b0; d4 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, RST_V);
        chk("rst_stall", stall_cycles, 0);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data_hold", out_data, RST_V);

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'h1111_0000 + 32'(i);
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, 32'h1111_0000 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", out_valid, 0);
        chk("stream_drain_bubble", out_data, BUB_V);
        chk("stream_stall", stall_cycles, 0);

        // Back-pressure into the skid entry
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        tick();
        chk("bp_A_valid", out_valid, 1);
        chk("bp_A_data", out_data, 32'hA);
        in_data = 32'hB;
        #1;
        chk("bp_B_ready", in_ready, 1);
        tick();
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_data", out_data, 32'hA);
        chk("bp_stall1", stall_cycles, 1);
        in_data = 32'hC;
        tick();
        chk("bp_hold_data", out_data, 32'hA);
        tick();
        chk("bp_hold_data2", out_data, 32'hA);
        chk("bp_C_held", in_ready, 0);
        chk("bp_stall3", stall_cycles, 3);
        out_ready = 1'b1;
        tick();
        chk("bp_B_out", out_data, 32'hB);
        chk("bp_B_valid", out_valid, 1);
        chk("bp_ready_back", in_ready, 1);
        tick();
        chk("bp_C_out", out_data, 32'hC);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", out_valid, 0);
        chk("bp_stall_final", stall_cycles, 3);

        // Flush while FULL with a concurrent beat offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_00A2;
        tick();
        in_data = 32'h0000_00B2;
        tick();
        chk("fl_full", in_ready, 0);
        flush = 1'b1; in_data = 32'h0000_00DD;
        #1;
        chk("fl_in_ready_low", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_valid", out_valid, 0);
        chk("fl_bubble", out_data, BUB_V);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_stall", stall_cycles, 5);
        out_ready = 1'b1;
        tick();
        chk("fl_D_dropped", out_valid, 0);
        in_valid = 1'b1; in_data = 32'h0000_00EE;
        tick();
        chk("fl_E_valid", out_valid, 1);
        chk("fl_E_data", out_data, 32'h0000_00EE);
        in_valid = 1'b0;
        tick();
        chk("fl_E_taken", out_valid, 0);

        // Asynchronous reset in mid-cycle while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0A0A;
        tick();
        in_data = 32'h0000_0B0B;
        tick();
        in_valid = 1'b0;
        chk("ar_full", in_ready, 0);
        chk("ar_stall_pre", stall_cycles, 6);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, RST_V);
        chk("ar_stall", stall_cycles, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("ar_in_ready", in_ready, 1);
        chk("ar_valid_after", out_valid, 0);

        // Narrow counter saturation
        iv4 = 1'b1; d4 = 8'h5A; or4 = 1'b0;
        tick();
        iv4 = 1'b0;
        chk("sat_start", st4, 0);
        repeat (14) tick();
        chk("sat_14", st4, 4'hE);
        tick();
        chk("sat_15", st4, 4'hF);
        repeat (5) tick();
        chk("sat_hold", st4, 4'hF);
        chk("sat_data_stable", od4, 8'h5A);
        chk("sat_valid_stable", ov4, 1);
        or4 = 1'b1;
        tick();
        chk("sat_drained", ov4, 0);
        chk("sat_after_take", st4, 4'hF);

        // Random traffic against a FIFO scoreboard
        stall_exp = stall_cycles;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            #1;
            exp_rdy = (q.size() < 2);
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_out_valid", out_valid, (q.size() > 0));
            if (q.size() > 0 && !out_ready && stall_exp != 16'hFFFF) stall_exp++;
            if (q.size() > 0 && out_ready) begin
                chk("rnd_out_data", out_data, q[0]);
                void'(q.pop_front());
            end
            if (in_valid && exp_rdy) q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        chk("rnd_stall", stall_cycles, stall_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised successor to the plain 32-bit pipeline latch used between CPU stages. It is a valid/ready pipeline stage with a 2-entry skid buffer, synchronous flush with bubble (NOP) insertion, and a saturating back-pressure counter. It sits between any two stages of the pipelined datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It gives full throughput with a registered in_ready, so no combinational ready path crosses stages.

Parameters:
WIDTH, 32, payload width in bits.
RESET_VAL, {WIDTH{1'b0}}, out_data value after reset.
BUBBLE_VAL, {WIDTH{1'b0}}, out_data value whenever out_valid=0 after reset; the default is the MIPS NOP, 32'h0.
CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous flush; kills all held entries.
in_valid  input  1  upstream beat valid.
in_ready  output  1  stage can accept a beat; equals ~skid_valid & ~flush.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  registered; out_data is valid.
out_ready  input  1  downstream accepts the beat.
out_data  output  WIDTH  registered payload.
stall_cycles  output  CNT_W  count of cycles with out_valid & ~out_ready; saturates at all-ones.

Behaviour:
- Handshake events:
  - acc = in_valid & in_ready.
  - take = out_valid & out_ready.
  - in_valid and out_ready carry no obligation unless paired with the opposite signal.
- Storage and state:
  - Main register holds {out_valid, out_data}; skid register holds {skid_valid, skid_data}.
  - State encoding: EMPTY (main empty, skid empty), ONE (main valid, skid empty), FULL (both valid).
- Reset (async, rst_n=0):
  - state=EMPTY, out_valid=0, out_data=RESET_VAL, skid_data=BUBBLE_VAL, stall_cycles=0.
  - in_ready=1 from the first cycle after release, provided flush=0.
- Transitions when flush=0:
  - EMPTY: acc -> ONE, main<=in_data. Otherwise stay.
  - ONE, acc & take -> ONE, main<=in_data.
  - ONE, acc & ~take -> FULL, skid<=in_data.
  - ONE, ~acc & take -> EMPTY, out_data<=BUBBLE_VAL.
  - ONE, neither -> hold.
  - FULL: in_ready=0, so acc cannot occur. take -> ONE, main<=skid_data, skid_data<=BUBBLE_VAL. Otherwise hold.
- Latency and ordering:
  - Accept-to-out_valid latency is 1 cycle.
  - Throughput is 1 beat/cycle in steady state.
  - Strict FIFO order; no beat is ever duplicated or dropped except by flush.
- Stability: out_data and out_valid stay unchanged while out_valid=1 and out_ready=0.
- Flush (priority over everything except reset):
  - Next state=EMPTY; out_valid=0, out_data=BUBBLE_VAL, skid cleared.
  - in_ready=0 in the flush cycle, so a concurrent in_valid beat is not accepted.
  - A concurrent take still counts as a delivered beat to downstream.
- Stall counter:
  - Increments by 1 each cycle with out_valid=1 & out_ready=0.
  - Holds at 2^CNT_W-1.
  - Unaffected by flush; cleared only by reset.
- Reset mid-operation: all entries are discarded immediately (async); no partial beats.
- Invariant: skid_valid=1 implies out_valid=1. State 2'b10 is illegal and must recover to EMPTY.

Decomposition:
- Shared header pipe_defs.vh:
  - state encodings ST_EMPTY=2'b00, ST_ONE=2'b01, ST_FULL=2'b11.
  - MIPS_NOP=32'h0000_0000 used as the BUBBLE_VAL default for instruction stages.
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, q): used for stall_cycles and reusable by the hazard unit.

Test Plan:
- Reset, then in_valid=1 with in_data=32'h1111_0001..0004 on 4 consecutive cycles, out_ready=1 -> out_valid rises 1 cycle after the first beat; out_data=...0001..0004 in order; in_ready stays 1; stall_cycles=0.
- Beat A=32'hA, then out_ready=0 for 3 cycles while offering B=32'hB and C=32'hC -> B enters skid, in_ready=0, C is held upstream; out_data stays 32'hA; stall_cycles=3. Release out_ready -> A, B, C delivered in order.
- FULL state (A in main, B in skid), flush=1 with in_valid=1 carrying D -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1; D is not delivered; later beat E is delivered normally.
- Assert rst_n=0 asynchronously in mid-cycle while FULL -> out_valid=0 and out_data=RESET_VAL before the next clock edge; after release, in_ready=1.
- CNT_W=4 build with out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles saturates at 4'hF and holds.
- Random in_valid/out_ready at 50% each, 10k cycles, with a scoreboard -> no loss, no duplication, order preserved; in_ready never depends combinationally on out_ready.
